neuron_mac_z: RTL

//  Serial multiply-accumulate stage for one neuron. Consumes N_INPUTS (x, w) pairs plus a bias,

---
 rtl/neuron_mac_z.sv | 129 ++++++++++++
 1 files changed

// File: rtl/neuron_mac_z.sv
// Serial MAC stage for one neuron: accumulates x*w pairs plus bias and
// emits the pre-activation z as an offset-128 Q4.4 code for the LUT stage.
module neuron_mac_z #(
    parameter int N_INPUTS = 4,
    parameter int CNT_W    = 3,
    parameter int ACC_W    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x_data,
    input  logic [7:0] w_data,
    input  logic [7:0] bias,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] z_value,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]               z_q, z_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [15:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_sh;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  s_val;
    logic signed [ACC_W-1:0]  t_val;
    logic [7:0]               z_sat;
    logic                     last_beat;

    // Product, bias alignment, rounding and saturation to the offset code
    always_comb begin
        prod      = $signed(x_data) * $signed(w_data);
        prod_ext  = {{(ACC_W-16){prod[15]}}, prod};
        bias_sh   = {{(ACC_W-12){bias[7]}}, bias, 4'b0000};
        rnd       = acc_q + ACC_W'(8);
        s_val     = rnd >>> 4;
        t_val     = s_val + ACC_W'(128);
        last_beat = (cnt_q == CNT_W'(N_INPUTS - 1));
        if (t_val[ACC_W-1]) begin
            z_sat = 8'h00;
        end else if (|t_val[ACC_W-2:8]) begin
            z_sat = 8'hFF;
        end else begin
            z_sat = t_val[7:0];
        end
    end

    // Next-state logic for ACC -> CALC -> OUT sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        z_d         = z_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    if (cnt_q == '0) begin
                        acc_d = bias_sh + prod_ext;
                    end else begin
                        acc_d = acc_q + prod_ext;
                    end
                    if (last_beat) begin
                        cnt_d      = '0;
                        state_d    = S_CALC;
                        in_ready_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CALC: begin
                z_d         = z_sat;
                state_d     = S_OUT;
                out_valid_d = 1'b1;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d     = S_ACC;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_ACC;
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            z_q         <= 8'h00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign z_value   = z_q;

endmodule
